// File: rtl/key_ctrl_pkg.sv
// Shared constants, channel mode type and counter sizing helper for the key controller.
package key_ctrl_pkg;

  localparam int unsigned DEBOUNCE_10MS_50M = 500_000;
  localparam int unsigned LONG_1S_50M       = 50_000_000;

  typedef enum logic {
    MODE_MOMENTARY = 1'b0,
    MODE_TOGGLE    = 1'b1
  } key_mode_e;

  // Bits needed to hold 0..max_count inclusive, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchronizer, debounce counter and registered press/release pulses.
module key_debounce
  import key_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50M
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      cnt           <= '0;
      key_level     <= 1'b0;
      level_q       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      // Level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
      if (sync2 == key_level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt       <= '0;
        key_level <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_q       <= key_level;
      press_pulse   <= key_level & ~level_q;
      release_pulse <= ~key_level & level_q;
    end
  end

endmodule

// File: rtl/key_toggle_array.sv
// Array of debounced keys driving per-channel toggle/momentary state bits.
// Optional long-press detection enabled by defining KEY_LONG_PRESS_EN.
module key_toggle_array
  import key_ctrl_pkg::*;
#(
  parameter int unsigned        N_KEYS          = 2,
  parameter int unsigned        DEBOUNCE_CYCLES = DEBOUNCE_10MS_50M,
  parameter logic [N_KEYS-1:0]  INIT_STATE      = 2'b10,
  parameter logic [N_KEYS-1:0]  TOGGLE_MASK     = '1,
  parameter int unsigned        LONG_CYCLES     = LONG_1S_50M
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] state_wr,
  input  logic [N_KEYS-1:0] state_wdata,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] state_out
);

  if (N_KEYS < 1 || N_KEYS > 32) begin : g_bad_keys
    $error("key_toggle_array: N_KEYS must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_timing
    $error("key_toggle_array: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    localparam key_mode_e MODE = key_mode_e'(TOGGLE_MASK[i]);

    logic state_q;
    logic long_evt;

    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_50m      (clk_50m),
      .rst          (rst),
      .key_in       (key_in[i]),
      .key_level    (key_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned LW = cnt_width(LONG_CYCLES);

    logic [LW-1:0] hold;
    logic          long_q;

    // Saturates at LONG_CYCLES so a held key fires only once per press.
    always_ff @(posedge clk_50m) begin
      if (rst || !key_level[i]) begin
        hold   <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= (hold == LW'(LONG_CYCLES - 1));
        if (hold != LW'(LONG_CYCLES)) begin
          hold <= hold + 1'b1;
        end
      end
    end

    assign long_evt      = long_q;
`else
    assign long_evt      = 1'b0;
`endif
    assign long_pulse[i] = long_evt;

    always_ff @(posedge clk_50m) begin
      if (rst) begin
        state_q <= INIT_STATE[i];
      end else if (state_wr[i]) begin
        state_q <= state_wdata[i];
      end else if (MODE == MODE_TOGGLE) begin
        if (long_evt) begin
          state_q <= INIT_STATE[i];
        end else if (press_pulse[i]) begin
          state_q <= ~state_q;
        end
      end else begin
        state_q <= INIT_STATE[i] ^ key_level[i];
      end
    end

    assign state_out[i] = state_q;
  end

endmodule

// File: tb/tb_key_toggle_array.sv
// Directed bench for key_toggle_array: debounce latency, glitch rejection, write priority,
// reset behaviour and long press (KEY_LONG_PRESS_EN) on a toggle and a momentary instance.
module tb_key_toggle_array;

  localparam int unsigned NK = 2;
  localparam int unsigned DB = 4;
  localparam int unsigned LC = 20;

  logic          clk_50m = 1'b0;
  logic          rst;
  logic [NK-1:0] key_in, state_wr, state_wdata;
  logic [NK-1:0] key_level, press_pulse, release_pulse, long_pulse, state_out;
  logic [NK-1:0] m_level, m_press, m_release, m_long, m_state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #10 clk_50m = ~clk_50m;

  key_toggle_array #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .INIT_STATE(2'b10),
    .TOGGLE_MASK(2'b11), .LONG_CYCLES(LC)
  ) u_dut (
    .clk_50m(clk_50m), .rst(rst), .key_in(key_in), .state_wr(state_wr),
    .state_wdata(state_wdata), .key_level(key_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_pulse(long_pulse), .state_out(state_out)
  );

  key_toggle_array #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .INIT_STATE(2'b10),
    .TOGGLE_MASK(2'b00), .LONG_CYCLES(LC)
  ) u_mom (
    .clk_50m(clk_50m), .rst(rst), .key_in(key_in), .state_wr(state_wr),
    .state_wdata(state_wdata), .key_level(m_level), .press_pulse(m_press),
    .release_pulse(m_release), .long_pulse(m_long), .state_out(m_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  initial begin
    rst = 1'b1; key_in = '0; state_wr = '0; state_wdata = '0;
    tick(); tick();
    check("rst_state", state_out, 2'b10);
    check("rst_level", key_level, 2'b00);
    check("rst_press", press_pulse, 2'b00);
    check("rst_mstate", m_state, 2'b10);
    rst = 1'b0;
    tick();

    // Glitch of 3 cycles must be rejected
    key_in = 2'b01;
    repeat (3) tick();
    key_in = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("glitch_press_k%0d", k), press_pulse, 2'b00);
      check($sformatf("glitch_level_k%0d", k), key_level, 2'b00);
    end
    check("glitch_state", state_out, 2'b10);

    // Single press/release on channel 0
    key_in = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("t1_press_k%0d", k), press_pulse, (k == 7) ? 2'b01 : 2'b00);
      if (k == 5) check("t1_level_k5", key_level, 2'b00);
      if (k == 6) check("t1_level_k6", key_level, 2'b01);
      if (k == 6) check("t1_mstate_k6", m_state, 2'b10);
      if (k == 7) check("t1_state_k7", state_out, 2'b10);
      if (k == 7) check("t1_mstate_k7", m_state, 2'b11);
      if (k == 8) check("t1_state_k8", state_out, 2'b11);
    end
    key_in = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("t1_rel_k%0d", k), release_pulse, (k == 7) ? 2'b01 : 2'b00);
      if (k == 7) check("t1_mstate_rel", m_state, 2'b10);
    end
    check("t1_state_after_rel", state_out, 2'b11);

    // Press on channel 1 coinciding with a write of 1
    key_in = 2'b10;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("t3_press_k%0d", k), press_pulse, (k == 7) ? 2'b10 : 2'b00);
    end
    state_wr = 2'b10; state_wdata = 2'b10;
    tick();
    state_wr = '0; state_wdata = '0;
    check("t3_wr_priority", state_out, 2'b11);
    check("t3_mwr_priority", m_state, 2'b10);
    key_in = 2'b00;
    repeat (10) tick();
    check("t3_state_after", state_out, 2'b11);

    // Both keys pressed together
    state_wr = 2'b11; state_wdata = 2'b10;
    tick();
    state_wr = '0; state_wdata = '0;
    check("t4_preset", state_out, 2'b10);
    key_in = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("t4_press_k%0d", k), press_pulse, (k == 7) ? 2'b11 : 2'b00);
      if (k == 8) check("t4_state", state_out, 2'b01);
    end
    key_in = 2'b00;
    repeat (10) tick();

    // Reset in the middle of a debounce
    key_in = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("t5_pre_press_k%0d", k), press_pulse, 2'b00);
    end
    rst = 1'b1;
    tick();
    check("t5_state_in_rst", state_out, 2'b10);
    check("t5_level_in_rst", key_level, 2'b00);
    check("t5_press_in_rst", press_pulse, 2'b00);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("t5_press_k%0d", k), press_pulse, (k == 7) ? 2'b01 : 2'b00);
      if (k == 8) check("t5_state", state_out, 2'b11);
    end
    key_in = 2'b00;
    repeat (10) tick();

    // Long hold on channel 0
    state_wr = 2'b11; state_wdata = 2'b10;
    tick();
    state_wr = '0; state_wdata = '0;
    key_in = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      tick();
`ifdef KEY_LONG_PRESS_EN
      check($sformatf("t6_long_k%0d", k), long_pulse, (k == 26) ? 2'b01 : 2'b00);
      if (k == 27) check("t6_state_k27", state_out, 2'b10);
`else
      check($sformatf("t6_long_k%0d", k), long_pulse, 2'b00);
      if (k == 27) check("t6_state_k27", state_out, 2'b11);
`endif
      if (k == 8) check("t6_state_k8", state_out, 2'b11);
    end
    key_in = 2'b00;
    repeat (10) tick();
    check("t6_long_after", long_pulse, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
